// File: rtl/vote_display_driver.sv
// vote_display_driver
// Front-panel output stage. Takes a 14-bit binary tally on a one-cycle load
// strobe, converts it to four BCD digits with a sequential shift-add-3
// (double dabble) engine, and scans the result onto a 4-digit multiplexed
// common-anode seven-segment display.
//
// Ports:
//   clk        system clock, everything on posedge
//   rst_n      synchronous active-low reset
//   value[13:0] binary value, sampled when a load is accepted
//   load       one-cycle load strobe
//   busy       high while a conversion is in flight
//   done       one-cycle pulse after new digits are committed
//   an[3:0]    digit enables, active-low, an[0] = units
//   seg[6:0]   segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low, always off
//   dbg_state  current FSM state (IDLE=0, CONV=1, COMMIT=2)
//
// Handshake: a load is accepted on any posedge where load==1 and busy==0;
// while busy==1 load is ignored entirely (no queuing, value not sampled).
module vote_display_driver #(
  parameter int REFRESH_BITS = 16,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [REFRESH_BITS-1:0] SCAN_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

  logic [1:0]              state_q,  state_d;
  logic [13:0]             bin_q,    bin_d;
  logic [15:0]             bcd_q,    bcd_d;
  logic [3:0]              shcnt_q,  shcnt_d;
  logic                    ovfp_q,   ovfp_d;    // overflow of the value being converted
  logic [15:0]             digits_q, digits_d;  // committed display digits
  logic                    ovf_q,    ovf_d;     // overflow of the committed value
  logic                    done_q,   done_d;
  logic [REFRESH_BITS-1:0] scan_q,   scan_d;

  // One double-dabble step: correct every nibble >=5, then shift {bcd,bin}.
  logic [15:0] bcd_adj;
  logic [29:0] shifted;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
    shifted = {bcd_adj[14:0], bin_q, 1'b0};
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    shcnt_d  = shcnt_q;
    ovfp_d   = ovfp_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    scan_d   = scan_q + SCAN_ONE;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          bin_d   = value;
          bcd_d   = 16'd0;
          shcnt_d = 4'd0;
          ovfp_d  = (value > 14'd9999);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d   = shifted[29:14];
        bin_d   = shifted[13:0];
        shcnt_d = shcnt_q + 4'd1;
        if (shcnt_q == 4'd13) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        digits_d = bcd_q;
        ovf_d    = ovfp_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bin_q    <= 14'd0;
      bcd_q    <= 16'd0;
      shcnt_q  <= 4'd0;
      ovfp_q   <= 1'b0;
      digits_q <= 16'd0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      scan_q   <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      shcnt_q  <= shcnt_d;
      ovfp_q   <= ovfp_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      scan_q   <= scan_d;
    end
  end

  // Display decode, purely combinational from registered state.
  logic [1:0] sel;
  logic [3:0] digit;
  logic [3:0] lz;        // lz[k]: digit k and everything above it are zero
  logic [6:0] seg_dec;

  always_comb begin
    sel   = scan_q[REFRESH_BITS-1 -: 2];
    digit = digits_q[{sel, 2'b00} +: 4];
    lz[3] = (digits_q[15:12] == 4'd0);
    lz[2] = lz[3] && (digits_q[11:8] == 4'd0);
    lz[1] = lz[2] && (digits_q[7:4] == 4'd0);
    lz[0] = 1'b0;      // units digit is always shown
    case (digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
    an = ~(4'b0001 << sel);
    if (ovf_q)                    seg = 7'b0111111;
    else if (BLANK_LZ && lz[sel]) seg = 7'b1111111;
    else                          seg = seg_dec;
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign dp        = 1'b1;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vote_display_driver.sv
module tb_vote_display_driver;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT 1: leading-zero blanking on
  logic [13:0] value;
  logic        load;
  logic        busy, done, dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [1:0]  dbg_state;

  // DUT 2: leading-zero blanking off
  logic [13:0] value2;
  logic        load2;
  logic        busy2, done2, dp2;
  logic [3:0]  an2;
  logic [6:0]  seg2;
  logic [1:0]  dbg_state2;

  vote_display_driver #(.REFRESH_BITS(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .busy(busy),
    .done(done), .an(an), .seg(seg), .dp(dp), .dbg_state(dbg_state)
  );

  vote_display_driver #(.REFRESH_BITS(4), .BLANK_LZ(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .value(value2), .load(load2), .busy(busy2),
    .done(done2), .an(an2), .seg(seg2), .dp(dp2), .dbg_state(dbg_state2)
  );

  // Reference scan position: free-running count since the last reset edge.
  logic [3:0] mcnt;
  always @(posedge clk) begin
    if (!rst_n) mcnt <= 4'd0;
    else        mcnt <= mcnt + 4'd1;
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load a value into one DUT and check busy/done across the full conversion.
  task automatic do_load(input string tag, input bit which, input logic [13:0] v);
    if (which) begin value2 = v; load2 = 1'b1; end
    else       begin value  = v; load  = 1'b1; end
    tick();                                   // edge N
    load = 1'b0; load2 = 1'b0;
    chk({tag, "_busyN"}, 16'(which ? busy2 : busy), 16'd1);
    chk({tag, "_doneN"}, 16'(which ? done2 : done), 16'd0);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk({tag, "_busy"}, 16'(which ? busy2 : busy), 16'd1);
      chk({tag, "_done"}, 16'(which ? done2 : done), 16'd0);
    end
    tick();                                   // edge N+15
    chk({tag, "_busy15"}, 16'(which ? busy2 : busy), 16'd0);
    chk({tag, "_done15"}, 16'(which ? done2 : done), 16'd1);
    tick();                                   // edge N+16
    chk({tag, "_done16"}, 16'(which ? done2 : done), 16'd0);
  endtask

  // Walk a full scan period and check every digit slot.
  task automatic check_disp(input string tag, input bit which,
                            input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0);
    logic [6:0] exp_s [4];
    logic [3:0] exp_an;
    int k;
    exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
    for (int i = 0; i < 16; i++) begin
      k = int'(mcnt[3:2]);
      exp_an = ~(4'b0001 << k);
      chk({tag, "_an"},  16'(which ? an2 : an),   16'(exp_an));
      chk({tag, "_seg"}, 16'(which ? seg2 : seg), 16'(exp_s[k]));
      chk({tag, "_dp"},  16'(which ? dp2 : dp),   16'd1);
      tick();
    end
  endtask

  int ndone;

  initial begin
    rst_n = 1'b0; load = 1'b0; load2 = 1'b0; value = '0; value2 = '0;
    tick(); tick();

    // 1: reset state and blanked scan
    chk("rst_an",    16'(an),        16'b1110);
    chk("rst_seg",   16'(seg),       16'(S0));
    chk("rst_busy",  16'(busy),      16'd0);
    chk("rst_done",  16'(done),      16'd0);
    chk("rst_dp",    16'(dp),        16'd1);
    chk("rst_state", 16'(dbg_state), 16'd0);
    rst_n = 1'b1;
    check_disp("idle0", 1'b0, SB, SB, SB, S0);
    check_disp("idle0_nb", 1'b1, S0, S0, S0, S0);

    // 2: 1234
    do_load("l1234", 1'b0, 14'd1234);
    check_disp("d1234", 1'b0, S1, S2, S3, S4);

    // 3: 9999 then overflow 10000
    do_load("l9999", 1'b0, 14'd9999);
    check_disp("d9999", 1'b0, S9, S9, S9, S9);
    do_load("l10000", 1'b0, 14'd10000);
    check_disp("d10000", 1'b0, SD, SD, SD, SD);

    // inner zero stays lit, leading zero blanked
    do_load("l305", 1'b0, 14'd305);
    check_disp("d305", 1'b0, SB, S3, S0, S5);

    // 4: second load during conversion is ignored
    do_load("l1234b", 1'b0, 14'd1234);
    do_load("l42pre", 1'b0, 14'd16383);       // max value, shows overflow
    check_disp("d16383", 1'b0, SD, SD, SD, SD);
    value = 14'd1234; load = 1'b1;
    tick();                                   // edge N
    load = 1'b0;
    chk("ign_state", 16'(dbg_state), 16'd1);
    ndone = 0;
    for (int i = 1; i <= 4; i++) begin tick(); ndone += int'(done); end
    value = 14'd42; load = 1'b1;
    tick();                                   // edge N+5
    ndone += int'(done);
    load = 1'b0;
    for (int i = 6; i <= 16; i++) begin tick(); ndone += int'(done); end
    chk("ign_ndone", 16'(ndone), 16'd1);
    chk("ign_busy",  16'(busy),  16'd0);
    check_disp("d_ign", 1'b0, S1, S2, S3, S4);

    // 5: reset mid-conversion
    value = 14'd5678; load = 1'b1;
    tick();                                   // edge N
    load = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    rst_n = 1'b0;
    tick();                                   // edge N+7 under reset
    chk("mid_busy", 16'(busy), 16'd0);
    chk("mid_done", 16'(done), 16'd0);
    chk("mid_an",   16'(an),   16'b1110);
    chk("mid_seg",  16'(seg),  16'(S0));
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin tick(); ndone += int'(done) + int'(busy); end
    chk("mid_quiet", 16'(ndone), 16'd0);
    check_disp("d_mid", 1'b0, SB, SB, SB, S0);
    do_load("l5678", 1'b0, 14'd5678);
    check_disp("d5678", 1'b0, S5, S6, S7, S8);

    // 6: no blanking
    do_load("nb7", 1'b1, 14'd7);
    check_disp("nb_d7", 1'b1, S0, S0, S0, S7);
    do_load("nb0", 1'b1, 14'd0);
    check_disp("nb_d0", 1'b1, S0, S0, S0, S0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
